// File: rtl/axi_sram_pkg.sv
// Shared constants, FSM state types and burst address helper for the AXI SRAM responder.
package axi_sram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    // WRAP is served as INCR; FIXED (and the reserved encoding) hold the address.
    function automatic logic [31:0] beat_next_addr(input logic [31:0] addr,
                                                   input logic [2:0]  size,
                                                   input logic [1:0]  burst);
        if (burst == BURST_INCR || burst == BURST_WRAP) begin
            return addr + (32'd1 << size);
        end
        return addr;
    endfunction

endpackage

// File: rtl/axi_sram_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that predicts next cycle's wait-state stall.
module axi_sram_lfsr (
    input  logic clock,
    input  logic reset,
    output logic stall_next_c
);

    logic [7:0] lfsr;
    logic [7:0] lfsr_next;

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // Lets the owner register its ready/valid outputs one cycle ahead of the stall.
    assign stall_next_c = (lfsr_next[1:0] == 2'b00);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 responder over a word-addressed SRAM with independent read and write FSMs.
// Define AXI_SRAM_DELAY_EN to inject pseudo-random wait states.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int unsigned MEM_AW = 16,
    parameter logic [31:0] BASE   = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_slave_awready,
    input  logic        io_slave_awvalid,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    input  logic [2:0]  io_slave_awsize,
    input  logic [1:0]  io_slave_awburst,
    output logic        io_slave_wready,
    input  logic        io_slave_wvalid,
    input  logic [31:0] io_slave_wdata,
    input  logic [3:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,
    input  logic        io_slave_bready,
    output logic        io_slave_bvalid,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,
    output logic        io_slave_arready,
    input  logic        io_slave_arvalid,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    input  logic [2:0]  io_slave_arsize,
    input  logic [1:0]  io_slave_arburst,
    input  logic        io_slave_rready,
    output logic        io_slave_rvalid,
    output logic [1:0]  io_slave_rresp,
    output logic [31:0] io_slave_rdata,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
);

    localparam int unsigned DEPTH = 1 << MEM_AW;

    logic [31:0] mem [DEPTH];

    rd_state_t   r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_beat;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [31:0] r_next_addr;

    wr_state_t   w_state;
    logic [31:0] w_addr;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_err;
    logic        w_fire;
    logic [31:0] w_next_addr;

    logic        stall_next;
    logic        unused_awlen;

    // Write beat count comes from wlast, so awlen carries no information here.
    assign unused_awlen = ^io_slave_awlen;

`ifdef AXI_SRAM_DELAY_EN
    axi_sram_lfsr u_lfsr (
        .clock        (clock),
        .reset        (reset),
        .stall_next_c (stall_next)
    );
`else
    assign stall_next = 1'b0;
`endif

    function automatic logic in_range(input logic [31:0] addr);
        return ((addr - BASE) >> (MEM_AW + 2)) == 32'd0;
    endfunction

    function automatic logic [MEM_AW-1:0] word_index(input logic [31:0] addr);
        return MEM_AW'((addr - BASE) >> 2);
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] addr);
        return in_range(addr) ? mem[word_index(addr)] : 32'd0;
    endfunction

    function automatic logic [1:0] decode_resp(input logic [31:0] addr);
        return in_range(addr) ? RESP_OKAY : RESP_DECERR;
    endfunction

    assign r_next_addr = beat_next_addr(r_addr, r_size, r_burst);
    assign w_next_addr = beat_next_addr(w_addr, w_size, w_burst);
    assign w_fire      = (w_state == W_DATA) && io_slave_wvalid && io_slave_wready;

    // Read FSM; beat data is fetched at the accepting edge so it sees pre-write contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= R_IDLE;
            io_slave_arready <= 1'b1;
            io_slave_rvalid  <= 1'b0;
            io_slave_rlast   <= 1'b0;
            io_slave_rresp   <= RESP_OKAY;
            io_slave_rdata   <= 32'd0;
            io_slave_rid     <= 4'd0;
            r_addr           <= 32'd0;
            r_len            <= 8'd0;
            r_beat           <= 8'd0;
            r_size           <= 3'd0;
            r_burst          <= BURST_FIXED;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (io_slave_arvalid && io_slave_arready) begin
                        r_state          <= R_DATA;
                        io_slave_arready <= 1'b0;
                        io_slave_rid     <= io_slave_arid;
                        r_addr           <= io_slave_araddr;
                        r_len            <= io_slave_arlen;
                        r_size           <= io_slave_arsize;
                        r_burst          <= io_slave_arburst;
                        r_beat           <= 8'd0;
                        io_slave_rvalid  <= !stall_next;
                        io_slave_rlast   <= (io_slave_arlen == 8'd0);
                        io_slave_rresp   <= decode_resp(io_slave_araddr);
                        io_slave_rdata   <= rd_word(io_slave_araddr);
                    end else begin
                        io_slave_arready <= !stall_next;
                    end
                end
                R_DATA: begin
                    if (!io_slave_rvalid) begin
                        io_slave_rvalid <= !stall_next;
                    end else if (io_slave_rready) begin
                        if (io_slave_rlast) begin
                            r_state          <= R_IDLE;
                            io_slave_rvalid  <= 1'b0;
                            io_slave_rlast   <= 1'b0;
                            io_slave_arready <= !stall_next;
                        end else begin
                            r_addr          <= r_next_addr;
                            r_beat          <= 8'(r_beat + 8'd1);
                            io_slave_rvalid <= !stall_next;
                            io_slave_rlast  <= (8'(r_beat + 8'd1) == r_len);
                            io_slave_rresp  <= decode_resp(r_next_addr);
                            io_slave_rdata  <= rd_word(r_next_addr);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM; w_err accumulates out-of-range beats for the burst's response.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state          <= W_IDLE;
            io_slave_awready <= 1'b1;
            io_slave_wready  <= 1'b0;
            io_slave_bvalid  <= 1'b0;
            io_slave_bresp   <= RESP_OKAY;
            io_slave_bid     <= 4'd0;
            w_addr           <= 32'd0;
            w_size           <= 3'd0;
            w_burst          <= BURST_FIXED;
            w_err            <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (io_slave_awvalid && io_slave_awready) begin
                        w_state          <= W_DATA;
                        io_slave_awready <= 1'b0;
                        io_slave_bid     <= io_slave_awid;
                        w_addr           <= io_slave_awaddr;
                        w_size           <= io_slave_awsize;
                        w_burst          <= io_slave_awburst;
                        w_err            <= 1'b0;
                        io_slave_wready  <= !stall_next;
                    end else begin
                        io_slave_awready <= !stall_next;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= w_next_addr;
                        if (!in_range(w_addr)) begin
                            w_err <= 1'b1;
                        end
                        if (io_slave_wlast) begin
                            w_state         <= W_RESP;
                            io_slave_wready <= 1'b0;
                            io_slave_bresp  <= (w_err || !in_range(w_addr)) ? RESP_DECERR : RESP_OKAY;
                            io_slave_bvalid <= !stall_next;
                        end else begin
                            io_slave_wready <= !stall_next;
                        end
                    end else begin
                        io_slave_wready <= !stall_next;
                    end
                end
                W_RESP: begin
                    if (!io_slave_bvalid) begin
                        io_slave_bvalid <= !stall_next;
                    end else if (io_slave_bready) begin
                        w_state          <= W_IDLE;
                        io_slave_bvalid  <= 1'b0;
                        io_slave_awready <= !stall_next;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Byte-strobed commit; out-of-range beats are dropped.
    always_ff @(posedge clock) begin
        if (!reset && w_fire && in_range(w_addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (io_slave_wstrb[b]) begin
                    mem[word_index(w_addr)][8*b +: 8] <= io_slave_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed scoreboard bench for axi_sram_slave: a byte-level memory model predicts
// every read beat and write response; outputs are sampled on the falling edge.
module tb_axi_sram_slave;
    import axi_sram_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] BYTES = 32'h0004_0000;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        awready, awvalid = 1'b0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awid = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'd2;
    logic [1:0]  awburst = BURST_INCR;
    logic        wready, wvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        bready = 1'b0, bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arready, arvalid = 1'b0;
    logic [31:0] araddr = '0;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = BURST_INCR;
    logic        rready = 1'b0, rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    int          checks = 0;
    int          errors = 0;
    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [31:0] model [logic [31:0]];
    logic [31:0] w_cur;
    logic [3:0]  w_id;
    logic        w_bad;

    axi_sram_slave dut (
        .clock            (clock),
        .reset            (reset),
        .io_slave_awready (awready),
        .io_slave_awvalid (awvalid),
        .io_slave_awaddr  (awaddr),
        .io_slave_awid    (awid),
        .io_slave_awlen   (awlen),
        .io_slave_awsize  (awsize),
        .io_slave_awburst (awburst),
        .io_slave_wready  (wready),
        .io_slave_wvalid  (wvalid),
        .io_slave_wdata   (wdata),
        .io_slave_wstrb   (wstrb),
        .io_slave_wlast   (wlast),
        .io_slave_bready  (bready),
        .io_slave_bvalid  (bvalid),
        .io_slave_bresp   (bresp),
        .io_slave_bid     (bid),
        .io_slave_arready (arready),
        .io_slave_arvalid (arvalid),
        .io_slave_araddr  (araddr),
        .io_slave_arid    (arid),
        .io_slave_arlen   (arlen),
        .io_slave_arsize  (arsize),
        .io_slave_arburst (arburst),
        .io_slave_rready  (rready),
        .io_slave_rvalid  (rvalid),
        .io_slave_rresp   (rresp),
        .io_slave_rdata   (rdata),
        .io_slave_rlast   (rlast),
        .io_slave_rid     (rid)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a - BASE) < BYTES;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] key = {a[31:2], 2'b00};
        logic [31:0] old = model.exists(key) ? model[key] : 32'h0;
        if (in_rng(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) old[8*b +: 8] = d[8*b +: 8];
            end
            model[key] = old;
        end
    endfunction

    function automatic void push_read(input logic [31:0] addr, input logic [7:0] len,
                                      input logic [1:0] burst, input logic [3:0] id);
        logic [31:0] a = addr;
        rexp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            e.id   = id;
            e.last = (i == int'(len));
            if (in_rng(a)) begin
                e.resp = RESP_OKAY;
                e.data = model.exists({a[31:2], 2'b00}) ? model[{a[31:2], 2'b00}] : 32'h0;
            end else begin
                e.resp = RESP_DECERR;
                e.data = 32'h0;
            end
            rq.push_back(e);
            if (burst != BURST_FIXED) a = a + 32'd4;
        end
    endfunction

    task automatic do_ar(input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] id, input logic [1:0] burst);
        int n = 0;
        push_read(addr, len, burst, id);
        @(negedge clock);
        araddr = addr; arlen = len; arid = id; arburst = burst; arvalid = 1'b1;
        while (!arready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("ar_accept", 32'(arready), 32'd1);
        @(negedge clock);
        arvalid = 1'b0;
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [3:0] id);
        int n = 0;
        w_cur = addr; w_id = id; w_bad = 1'b0;
        @(negedge clock);
        awaddr = addr; awid = id; awburst = BURST_INCR; awvalid = 1'b1;
        while (!awready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("aw_accept", 32'(awready), 32'd1);
        @(negedge clock);
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last);
        int n = 0;
        @(negedge clock);
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        while (!wready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("w_accept", 32'(wready), 32'd1);
        model_write(w_cur, d, s);
        if (!in_rng(w_cur)) w_bad = 1'b1;
        w_cur = w_cur + 32'd4;
        if (last) begin
            bq.push_back('{resp: (w_bad ? RESP_DECERR : RESP_OKAY), id: w_id});
            @(negedge clock);
            wvalid = 1'b0; wlast = 1'b0;
        end
    endtask

    task automatic collect_r(input int nbeats, input bit toggle);
        int n = 0;
        int got = 0;
        bit stalled = 1'b0;
        rexp_t e;
        while (got < nbeats && n < 200) begin
            @(negedge clock);
            n++;
            rready = toggle ? n[0] : 1'b1;
            if (stalled) check("r_valid_hold", 32'(rvalid), 32'd1);
            if (rvalid) begin
                check("r_expected", 32'(rq.size() != 0), 32'd1);
                if (rq.size() != 0) begin
                    e = rq[0];
                    check("r_data", rdata, e.data);
                    if (rready) begin
                        check("r_resp", 32'(rresp), 32'(e.resp));
                        check("r_last", 32'(rlast), 32'(e.last));
                        check("r_id", 32'(rid), 32'(e.id));
                        void'(rq.pop_front());
                        got++;
                    end
                end
            end
            stalled = rvalid && !rready;
        end
        check("r_beats", 32'(got), 32'(nbeats));
        @(negedge clock);
        rready = 1'b0;
    endtask

    task automatic collect_b(input bit toggle);
        int n = 0;
        bit done = 1'b0;
        bit stalled = 1'b0;
        bexp_t e;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
            bready = toggle ? n[0] : 1'b1;
            if (stalled) check("b_valid_hold", 32'(bvalid), 32'd1);
            if (bvalid && bready) begin
                check("b_expected", 32'(bq.size() != 0), 32'd1);
                if (bq.size() != 0) begin
                    e = bq.pop_front();
                    check("b_resp", 32'(bresp), 32'(e.resp));
                    check("b_id", 32'(bid), 32'(e.id));
                end
                done = 1'b1;
            end
            stalled = bvalid && !bready;
        end
        check("b_done", 32'(done), 32'd1);
        @(negedge clock);
        bready = 1'b0;
    endtask

    initial begin
        int n;

        // Reset values
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rid", 32'(rid), 32'd0);
        check("rst_bid", 32'(bid), 32'd0);

        // Preload word 4 through the bus, then single read
        do_aw(32'h8000_0010, 4'h3);
        do_w(32'hDEAD_BEEF, 4'hF, 1'b1);
`ifndef AXI_SRAM_DELAY_EN
        check("b_latency", 32'(bvalid), 32'd1);
`endif
        collect_b(1'b1);
        do_ar(32'h8000_0010, 8'd0, 4'h5, BURST_INCR);
`ifndef AXI_SRAM_DELAY_EN
        check("r_latency", 32'(rvalid), 32'd1);
`endif
        collect_r(1, 1'b0);

        // Four-beat INCR write, then INCR read with rready toggling
        do_aw(32'h8000_0000, 4'hA);
        for (int i = 0; i < 4; i++) do_w(32'h1000_0000 + 32'(i * 17), 4'hF, i == 3);
        collect_b(1'b0);
        do_ar(32'h8000_0000, 8'd3, 4'h2, BURST_INCR);
        collect_r(4, 1'b1);

        // WRAP behaves as INCR; FIXED repeats the same word
        do_ar(32'h8000_0004, 8'd1, 4'h6, BURST_WRAP);
        collect_r(2, 1'b0);
        do_ar(32'h8000_0010, 8'd2, 4'h7, BURST_FIXED);
        collect_r(3, 1'b1);

        // Byte strobes over an all-ones word
        do_aw(32'h8000_0004, 4'h2);
        do_w(32'hFFFF_FFFF, 4'hF, 1'b1);
        collect_b(1'b0);
        do_aw(32'h8000_0004, 4'hC);
        do_w(32'h1122_3344, 4'b0101, 1'b1);
        collect_b(1'b0);
        do_ar(32'h8000_0004, 8'd0, 4'h1, BURST_INCR);
        collect_r(1, 1'b0);

        // Out-of-range reads on both sides of the window
        do_ar(32'h7FFF_FFFC, 8'd0, 4'h8, BURST_INCR);
        collect_r(1, 1'b0);
        do_ar(BASE + BYTES, 8'd0, 4'h9, BURST_INCR);
        collect_r(1, 1'b0);

        // Write burst crossing the top of the window
        do_aw(BASE + BYTES - 32'd4, 4'h9);
        do_w(32'hAABB_CCDD, 4'hF, 1'b0);
        do_w(32'h1234_5678, 4'hF, 1'b1);
        collect_b(1'b1);
        do_ar(BASE + BYTES - 32'd4, 8'd1, 4'h4, BURST_INCR);
        collect_r(2, 1'b0);

        // Fresh in-range write clears the error flag
        do_aw(32'h8000_0020, 4'hB);
        do_w(32'h5555_0000, 4'hF, 1'b1);
        collect_b(1'b0);

        // Read and write of the same word on the same edge
        do_aw(32'h8000_0020, 4'h6);
        n = 0;
        while (!(wready && arready) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("rw_both_ready", 32'(wready && arready), 32'd1);
        push_read(32'h8000_0020, 8'd0, BURST_INCR, 4'hE);
        araddr = 32'h8000_0020; arlen = 8'd0; arid = 4'hE; arburst = BURST_INCR; arvalid = 1'b1;
        wdata = 32'h6666_7777; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        model_write(32'h8000_0020, 32'h6666_7777, 4'hF);
        bq.push_back('{resp: RESP_OKAY, id: 4'h6});
        @(negedge clock);
        arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        collect_r(1, 1'b0);
        collect_b(1'b0);
        do_ar(32'h8000_0020, 8'd0, 4'hE, BURST_INCR);
        collect_r(1, 1'b0);

        // Reset in the middle of a long burst
        do_ar(32'h8000_0000, 8'd7, 4'h4, BURST_INCR);
        collect_r(1, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        check("midrst_arready", 32'(arready), 32'd1);
        check("midrst_bvalid", 32'(bvalid), 32'd0);
        reset = 1'b0;
        rq.delete();
        do_ar(32'h8000_0010, 8'd0, 4'h1, BURST_INCR);
        collect_r(1, 1'b1);
        check("rq_drained", 32'(rq.size()), 32'd0);
        check("bq_drained", 32'(bq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 responder modelling word-addressed on-chip SRAM. It sits at the far end of the bus driven by the CPU/MMU path, serving instruction fetches, data accesses and the MMU's page-table-walk reads. Read and write channels are independent. Reads support multi-beat bursts; writes use byte-strobed bursts.

## Interface
- MEM_AW, 16, word-index width; capacity is 4·2^MEM_AW bytes
- BASE, 32'h8000_0000, byte address of word 0
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- io_slave_awready/awvalid/awaddr[31:0]/awid[3:0]/awlen[7:0]/awsize[2:0]/awburst[1:0]: AW channel (ready out, rest in)
- io_slave_wready/wvalid/wdata[31:0]/wstrb[3:0]/wlast: W channel (ready out, rest in)
- io_slave_bready/bvalid/bresp[1:0]/bid[3:0]: B channel (bready in, rest out)
- io_slave_arready/arvalid/araddr[31:0]/arid[3:0]/arlen[7:0]/arsize[2:0]/arburst[1:0]: AR channel (ready out, rest in)
- io_slave_rready/rvalid/rresp[1:0]/rdata[31:0]/rlast/rid[3:0]: R channel (rready in, rest out)

## Operation
- Read FSM states:
  - R_IDLE: arready=1.
  - R_DATA: rvalid=1.
  - AR handshake latches id, addr, len, size, burst; beat counter is cleared; state goes to R_DATA.
  - Each R handshake: beat++. The address advances by 1<<size when burst==INCR (01) or WRAP (10). WRAP is treated as INCR. The address is held when burst==FIXED (00).
  - rlast = (beat==len). A handshake with rlast set returns the FSM to R_IDLE.
- Write FSM states:
  - W_IDLE: awready=1, wready=0.
  - W_DATA: wready=1.
  - W_RESP: bvalid=1.
  - AW handshake latches id, addr, burst, size and moves to W_DATA.
  - Each W handshake writes the bytes enabled by wstrb to the current word, then advances the address as for reads.
  - A W handshake with wlast set moves to W_RESP. A B handshake returns to W_IDLE.
  - The W data count is set by wlast, not by awlen.
  - W beats presented while in W_IDLE are not accepted.
- Decode: offset = addr−BASE (32-bit wrap). In range when offset < 4·2^MEM_AW. Word index = offset[MEM_AW+1:2]. Byte lanes follow addr[1:0] via wstrb; rdata always returns the full word.
- Out-of-range read beat: rresp=2'b11 (DECERR), rdata=0.
- Out-of-range write beat: the write is dropped and a sticky DECERR flag is set. bresp=11 if any beat of the burst was out of range, else 00. The flag clears on the AW handshake.
- rid/bid echo the latched id.
- Memory contents are not reset.

## Timing
- Values after reset: arready=1, awready=1, wready=0, rvalid=0, rlast=0, bvalid=0, rresp=bresp=0, rid=bid=0.
- Read latency: AR handshake in cycle N gives rvalid in cycle N+1.
- With rready held high, one beat per cycle is delivered. rdata/rresp/rlast are stable while rvalid && !rready.
- Write: the beat commits at the W handshake edge. bvalid rises the cycle after the wlast handshake and is held until bready.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data; the write commits.
- arready/awready are low outside their idle states, so there is no back-to-back AR acceptance in the last R-beat cycle. The next AR is accepted at the earliest one cycle after the rlast handshake.
- Once asserted, rvalid and bvalid never drop before their handshake.
- Reset mid-burst: both FSMs go to idle at the next edge. All valids drop and the remaining beats are abandoned.

## Configuration
- AXI_SRAM_DELAY_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - When lfsr[1:0]==2'b00: arready, awready and wready are forced low that cycle.
  - A pending rvalid/bvalid rise is postponed, one cycle per stall cycle. A valid that is already asserted is never withdrawn.
- Macro undefined: zero wait states, timing exactly as above. The LFSR is not instantiated.

## Structure
- Package axi_sram_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/DECERR constants, read/write state enums, beat-address-increment function.
- Sub-module axi_sram_lfsr (8-bit, stall output), instantiated only under AXI_SRAM_DELAY_EN.
- The memory array and both FSMs live in the top.

## Test plan
- Single read, araddr=8000_0010, preloaded 32'hDEAD_BEEF → rvalid at N+1, rdata=DEADBEEF, rlast=1, rresp=00, rid=arid.
- INCR read burst arlen=3 at 8000_0000, rready toggling 1/0 → 4 beats of words 0..3 in order, rlast only on the 4th beat, data stable while stalled.
- Write 8000_0004 wdata=11223344 wstrb=4'b0101 over 0xFFFFFFFF, then read it back → 0xFF22FF44, bresp=00, bid=awid.
- Read at 7FFF_FFFC and at BASE+4·2^MEM_AW → rresp=11, rdata=0. A 2-beat write whose second beat crosses the top of range → bresp=11, first beat committed.
- Concurrent read and write of 8000_0020 in the same cycle → the read returns the old value; a subsequent read returns the new value.
- Reset asserted during beat 2 of an arlen=7 burst → rvalid=0 the next cycle, arready=1. A fresh AR is then served normally. With AXI_SRAM_DELAY_EN defined, the same scenarios give identical data/resp, and all valids are held until their handshake.
